// File: rtl/safe_pkg.sv
// Shared definitions for the combo-safe attempt controller: FSM state
// encoding, keypad code constants, failure counter width and the helper
// that computes the length of each escalating lockout.
package safe_pkg;

   typedef enum logic [1:0] {
      ACCEPT      = 2'd0,
      WAIT_RESULT = 2'd1,
      LOCKOUT     = 2'd2,
      ALARM       = 2'd3
   } safeState_t;

   localparam logic [3:0] KEY_ENTER = 4'hE;
   localparam logic [3:0] KEY_CLEAR = 4'hF;

   localparam int FAIL_W   = 4;
   localparam int FAIL_MAX = (1 << FAIL_W) - 1;

   // Lockout number lockIndex (0 for the first) lasts baseSecs doubled
   // lockIndex times, saturating at 255 seconds.
   function automatic logic [7:0] lockSeconds(input int lockIndex, input int baseSecs);
      int v;
      v = (baseSecs > 255) ? 255 : baseSecs;
      for (int i = 0; i < 16; i++) begin
         if (i < lockIndex) begin
            v = (v * 2 > 255) ? 255 : v * 2;
         end
      end
      return v[7:0];
   endfunction

endpackage

// File: rtl/safe_attempt_ctrl_if.sv
// Key and compare handshake between the keypad sampler, this controller
// and the combo-safe datapath. The controller takes the slave view; the
// environment (sampler + datapath) takes the master view.
interface safe_attempt_ctrl_if;

   logic       key_pulse_i;
   logic [3:0] key_code_i;
   logic       check_done_i;
   logic       match_i;
   logic       key_pulse_o;
   logic [3:0] key_code_o;

   modport master (
      output key_pulse_i,
      output key_code_i,
      output check_done_i,
      output match_i,
      input  key_pulse_o,
      input  key_code_o
   );

   modport slave (
      input  key_pulse_i,
      input  key_code_i,
      input  check_done_i,
      input  match_i,
      output key_pulse_o,
      output key_code_o
   );

endinterface

// File: rtl/sec_ticker.sv
// Free-running one-second prescaler for the lockout timer. While enabled it
// counts 0..CLK_HZ-1 and emits a single-cycle tick on the wrap cycle; clr
// (or reset) parks it at zero so every lockout starts with a full second.
module sec_ticker #(
   parameter int CLK_HZ = 50000000
) (
   input  logic MAX10_CLK1_50,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

   logic [CW-1:0] r_count;
   logic          w_wrap;

   assign w_wrap = (r_count == LAST);
   assign tick   = en && !clr && w_wrap;

   // Prescaler: cleared on reset or clr, otherwise advances and wraps while enabled.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (!reset || clr) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= w_wrap ? '0 : r_count + CW'(1);
      end
   end

endmodule

// File: rtl/safe_attempt_ctrl.sv
// Attempt controller between the keypad sampler and the combo-safe datapath.
// Forwards keys only while accepting, sequences each enter/compare, counts
// consecutive wrong combinations, imposes escalating timed lockouts and
// latches an alarm after too many failures.
// Optional build macro SAFE_ALARM_CLEAR_EN adds alarm_clear_i, which lets a
// one-cycle pulse leave ALARM; without it only reset leaves ALARM.
module safe_attempt_ctrl
   import safe_pkg::*;
#(
   parameter int CLK_HZ         = 50000000,
   parameter int FAILS_PER_LOCK = 3,
   parameter int BASE_LOCK_S    = 5,
   parameter int ALARM_FAILS    = 9,
   parameter int RESULT_TIMEOUT = 15
) (
   input  logic                MAX10_CLK1_50,
   input  logic                reset,
   safe_attempt_ctrl_if.slave  bus,
`ifdef SAFE_ALARM_CLEAR_EN
   input  logic                alarm_clear_i,
`endif
   output logic                lockout_o,
   output logic                alarm_o,
   output logic [FAIL_W-1:0]   fail_count_o,
   output logic [7:0]          lock_secs_o
);

   localparam int TW = (RESULT_TIMEOUT > 1) ? $clog2(RESULT_TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(RESULT_TIMEOUT - 1);

   safeState_t        r_state;
   logic [FAIL_W-1:0] r_failCount;
   logic [7:0]        r_lockSecs;
   logic [TW-1:0]     r_timeout;
   logic              r_keyPulse;
   logic [3:0]        r_keyCode;
   logic              r_lockout;
   logic              r_alarm;

   safeState_t        w_nextState;
   logic [FAIL_W-1:0] w_nextFail;
   logic [FAIL_W-1:0] w_failInc;
   logic [7:0]        w_nextSecs;
   logic [TW-1:0]     w_nextTimeout;
   logic              w_failEvent;
   logic              w_forward;
   logic              w_tick;
   logic              w_inLockout;

   assign w_inLockout = (r_state == LOCKOUT);

   sec_ticker #(
      .CLK_HZ(CLK_HZ)
   ) u_secTicker (
      .MAX10_CLK1_50(MAX10_CLK1_50),
      .reset        (reset),
      .clr          (!w_inLockout),
      .en           (w_inLockout),
      .tick         (w_tick)
   );

   // Next-state logic: key gating, result/timeout scoring, lockout countdown
   // and alarm handling, with failure escalation applied last.
   always_comb begin
      w_nextState   = r_state;
      w_nextFail    = r_failCount;
      w_nextSecs    = r_lockSecs;
      w_nextTimeout = r_timeout;
      w_failEvent   = 1'b0;
      w_forward     = bus.key_pulse_i && (r_state == ACCEPT);
      w_failInc     = (r_failCount == FAIL_W'(FAIL_MAX)) ? r_failCount
                                                          : r_failCount + FAIL_W'(1);

      case (r_state)
         ACCEPT: begin
            if (w_forward && (bus.key_code_i == KEY_ENTER)) begin
               w_nextState   = WAIT_RESULT;
               w_nextTimeout = '0;
            end
         end
         WAIT_RESULT: begin
            if (bus.check_done_i) begin
               if (bus.match_i) begin
                  w_nextFail  = '0;
                  w_nextState = ACCEPT;
               end else begin
                  w_failEvent = 1'b1;
               end
            end else if (r_timeout == TO_LAST) begin
               w_failEvent = 1'b1;
            end else begin
               w_nextTimeout = r_timeout + TW'(1);
            end
         end
         LOCKOUT: begin
            if (w_tick) begin
               if (r_lockSecs <= 8'd1) begin
                  w_nextSecs  = 8'd0;
                  w_nextState = ACCEPT;
               end else begin
                  w_nextSecs = r_lockSecs - 8'd1;
               end
            end
         end
         ALARM: begin
`ifdef SAFE_ALARM_CLEAR_EN
            if (alarm_clear_i) begin
               w_nextFail  = '0;
               w_nextState = ACCEPT;
            end
`endif
         end
         default: begin
            w_nextState = ACCEPT;
         end
      endcase

      if (w_failEvent) begin
         w_nextFail = w_failInc;
         if (int'(w_failInc) >= ALARM_FAILS) begin
            w_nextState = ALARM;
         end else if ((int'(w_failInc) % FAILS_PER_LOCK) == 0) begin
            w_nextState = LOCKOUT;
            w_nextSecs  = lockSeconds(int'(w_failInc) / FAILS_PER_LOCK - 1, BASE_LOCK_S);
         end else begin
            w_nextState = ACCEPT;
         end
      end
   end

   // State register plus the registered status outputs derived from the next state.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (!reset) begin
         r_state     <= ACCEPT;
         r_failCount <= '0;
         r_lockSecs  <= 8'd0;
         r_timeout   <= '0;
         r_lockout   <= 1'b0;
         r_alarm     <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_failCount <= w_nextFail;
         r_lockSecs  <= (w_nextState == LOCKOUT) ? w_nextSecs : 8'd0;
         r_timeout   <= w_nextTimeout;
         r_lockout   <= (w_nextState == LOCKOUT);
         r_alarm     <= (w_nextState == ALARM);
      end
   end

   // Key forwarding: one-cycle delayed copy of keys that arrive while accepting;
   // the code holds its last forwarded value otherwise.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (!reset) begin
         r_keyPulse <= 1'b0;
         r_keyCode  <= 4'h0;
      end else begin
         r_keyPulse <= w_forward;
         if (w_forward) begin
            r_keyCode <= bus.key_code_i;
         end
      end
   end

   assign bus.key_pulse_o = r_keyPulse;
   assign bus.key_code_o  = r_keyCode;
   assign lockout_o       = r_lockout;
   assign alarm_o         = r_alarm;
   assign fail_count_o    = r_failCount;
   assign lock_secs_o     = r_lockSecs;

endmodule

// File: tb/tb_safe_attempt_ctrl.sv
// Testbench for safe_attempt_ctrl: a vector table for the basic key/compare
// flow, hand sequences for lockout, alarm, timeout and reset corners, and a
// randomized run, all checked against a deadline-based behavioural model.
module tb_safe_attempt_ctrl;

   localparam int CLK_HZ_T  = 10;
   localparam int BASE_S    = 2;
   localparam int FPL       = 3;
   localparam int ALARM_N   = 9;
   localparam int TIMEOUT_N = 15;

   logic       sysClock;
   logic       resetN;
   logic       alarmClear;
   logic       lockout;
   logic       alarm;
   logic [3:0] failCount;
   logic [7:0] lockSecs;

   safe_attempt_ctrl_if busIf ();

   safe_attempt_ctrl #(
      .CLK_HZ        (CLK_HZ_T),
      .FAILS_PER_LOCK(FPL),
      .BASE_LOCK_S   (BASE_S),
      .ALARM_FAILS   (ALARM_N),
      .RESULT_TIMEOUT(TIMEOUT_N)
   ) dut (
      .MAX10_CLK1_50(sysClock),
      .reset        (resetN),
      .bus          (busIf.slave),
`ifdef SAFE_ALARM_CLEAR_EN
      .alarm_clear_i(alarmClear),
`endif
      .lockout_o    (lockout),
      .alarm_o      (alarm),
      .fail_count_o (failCount),
      .lock_secs_o  (lockSecs)
   );

   initial sysClock = 1'b0;
   always #5 sysClock = ~sysClock;

   int checks = 0;
   int passes = 0;

   // Behavioural model: mode plus start-of-phase timestamps; remaining
   // lockout seconds and timeouts are derived from elapsed cycles.
   localparam int M_ACCEPT = 0;
   localparam int M_WAIT   = 1;
   localparam int M_LOCK   = 2;
   localparam int M_ALARM  = 3;

   int         nCycle    = 0;
   int         mMode     = M_ACCEPT;
   int         mFail     = 0;
   int         mWaitAt   = 0;
   int         mLockAt   = 0;
   int         mLockLen  = 0;
   logic       ePulse    = 1'b0;
   logic [3:0] eCode     = 4'h0;

   function automatic int modelSecs();
      if (mMode != M_LOCK) return 0;
      return mLockLen - (nCycle - mLockAt) / CLK_HZ_T;
   endfunction

   task automatic modelFail();
      int f;
      f = (mFail + 1 > 15) ? 15 : mFail + 1;
      mFail = f;
      if (f >= ALARM_N) begin
         mMode = M_ALARM;
      end else if (f % FPL == 0) begin
         mMode    = M_LOCK;
         mLockAt  = nCycle;
         mLockLen = BASE_S << (f / FPL - 1);
         if (mLockLen > 255) mLockLen = 255;
      end else begin
         mMode = M_ACCEPT;
      end
   endtask

   task automatic modelStep(input logic rst, input logic kp, input logic [3:0] kc,
                            input logic cd, input logic mt, input logic ac);
      nCycle++;
      if (!rst) begin
         mMode  = M_ACCEPT;
         mFail  = 0;
         ePulse = 1'b0;
         eCode  = 4'h0;
         return;
      end
      ePulse = kp && (mMode == M_ACCEPT);
      if (ePulse) eCode = kc;
      case (mMode)
         M_ACCEPT: begin
            if (kp && kc == 4'hE) begin
               mMode   = M_WAIT;
               mWaitAt = nCycle;
            end
         end
         M_WAIT: begin
            if (cd) begin
               if (mt) begin
                  mFail = 0;
                  mMode = M_ACCEPT;
               end else begin
                  modelFail();
               end
            end else if (nCycle - mWaitAt == TIMEOUT_N) begin
               modelFail();
            end
         end
         M_LOCK: begin
            if (nCycle - mLockAt == mLockLen * CLK_HZ_T) mMode = M_ACCEPT;
         end
         default: begin
`ifdef SAFE_ALARM_CLEAR_EN
            if (ac) begin
               mMode = M_ACCEPT;
               mFail = 0;
            end
`endif
         end
      endcase
   endtask

   task automatic expectVal(input string name, input int act, input int exp);
      checks++;
      if (act == exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s @cycle %0d: got %0d, want %0d", name, nCycle, act, exp);
      end
   endtask

   // Compare every DUT output against the model.
   task automatic checkOutput(input string tag);
      expectVal({tag, ".key_pulse_o"}, int'(busIf.key_pulse_o), int'(ePulse));
      expectVal({tag, ".key_code_o"},  int'(busIf.key_code_o),  int'(eCode));
      expectVal({tag, ".lockout_o"},   int'(lockout),           (mMode == M_LOCK)  ? 1 : 0);
      expectVal({tag, ".alarm_o"},     int'(alarm),             (mMode == M_ALARM) ? 1 : 0);
      expectVal({tag, ".fail_count_o"}, int'(failCount),        mFail);
      expectVal({tag, ".lock_secs_o"}, int'(lockSecs),          modelSecs());
   endtask

   task automatic applyStimulus(input logic rst, input logic kp, input logic [3:0] kc,
                                input logic cd, input logic mt, input string tag);
      resetN             = rst;
      busIf.key_pulse_i  = kp;
      busIf.key_code_i   = kc;
      busIf.check_done_i = cd;
      busIf.match_i      = mt;
      @(posedge sysClock);
      #1;
      modelStep(rst, kp, kc, cd, mt, alarmClear);
      checkOutput(tag);
      busIf.key_pulse_i  = 1'b0;
      busIf.check_done_i = 1'b0;
      busIf.match_i      = 1'b0;
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, tag);
   endtask

   task automatic failOnce(input string tag);
      applyStimulus(1'b1, 1'b1, 4'hE, 1'b0, 1'b0, tag);
      applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, tag);
      applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, tag);
   endtask

   typedef struct {
      logic       rst;
      logic       kp;
      logic [3:0] kc;
      logic       cd;
      logic       mt;
      logic       xPulse;
      logic [3:0] xCode;
      logic [3:0] xFail;
      logic       xLock;
      logic       xAlarm;
      logic [7:0] xSecs;
   } vec_t;

   vec_t vecs[9];

   initial begin
      resetN             = 1'b0;
      alarmClear         = 1'b0;
      busIf.key_pulse_i  = 1'b0;
      busIf.key_code_i   = 4'h0;
      busIf.check_done_i = 1'b0;
      busIf.match_i      = 1'b0;

      //          rst kp code  cd mt | pulse code fail lock alarm secs
      vecs[0] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 8'd0};
      vecs[1] = '{1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 4'h1, 4'd0, 1'b0, 1'b0, 8'd0};
      vecs[2] = '{1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 4'h2, 4'd0, 1'b0, 1'b0, 8'd0};
      vecs[3] = '{1'b1, 1'b1, 4'hE, 1'b0, 1'b0, 1'b1, 4'hE, 4'd0, 1'b0, 1'b0, 8'd0};
      vecs[4] = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 4'hE, 4'd0, 1'b0, 1'b0, 8'd0};
      vecs[5] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'hE, 4'd0, 1'b0, 1'b0, 8'd0};
      vecs[6] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'hE, 4'd0, 1'b0, 1'b0, 8'd0};
      vecs[7] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'hE, 4'd0, 1'b0, 1'b0, 8'd0};
      vecs[8] = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 4'h3, 4'd0, 1'b0, 1'b0, 8'd0};

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].kp, vecs[i].kc, vecs[i].cd, vecs[i].mt,
                       $sformatf("vec%0d", i));
         expectVal($sformatf("vec%0d.pulse", i), int'(busIf.key_pulse_o), int'(vecs[i].xPulse));
         expectVal($sformatf("vec%0d.code", i),  int'(busIf.key_code_o),  int'(vecs[i].xCode));
         expectVal($sformatf("vec%0d.fail", i),  int'(failCount),         int'(vecs[i].xFail));
         expectVal($sformatf("vec%0d.lock", i),  int'(lockout),           int'(vecs[i].xLock));
         expectVal($sformatf("vec%0d.alarm", i), int'(alarm),             int'(vecs[i].xAlarm));
         expectVal($sformatf("vec%0d.secs", i),  int'(lockSecs),          int'(vecs[i].xSecs));
      end

      // First lockout: 2 s at 10 cycles/s, keys pressed throughout.
      idle(1, "settle");
      for (int i = 0; i < 3; i++) failOnce("fail1");
      expectVal("lock1.fail", int'(failCount), 3);
      expectVal("lock1.lockout", int'(lockout), 1);
      expectVal("lock1.secs", int'(lockSecs), 2);
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 4'h7, 1'b0, 1'b0, "lock1keys");
      expectVal("lock1.secs9", int'(lockSecs), 2);
      applyStimulus(1'b1, 1'b1, 4'h7, 1'b0, 1'b0, "lock1keys");
      expectVal("lock1.secs10", int'(lockSecs), 1);
      expectVal("lock1.nofwd", int'(busIf.key_pulse_o), 0);
      idle(9, "lock1wait");
      expectVal("lock1.still19", int'(lockout), 1);
      idle(1, "lock1end");
      expectVal("lock1.end20", int'(lockout), 0);
      expectVal("lock1.secs20", int'(lockSecs), 0);

      // Second lockout doubles; ninth failure alarms.
      for (int i = 0; i < 3; i++) failOnce("fail2");
      expectVal("lock2.fail", int'(failCount), 6);
      expectVal("lock2.secs", int'(lockSecs), 4);
      idle(40, "lock2wait");
      expectVal("lock2.end", int'(lockout), 0);
      for (int i = 0; i < 3; i++) failOnce("fail3");
      expectVal("alarm.on", int'(alarm), 1);
      expectVal("alarm.fail", int'(failCount), 9);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 4'h4, 1'b1, 1'b1, "alarmkeys");
      expectVal("alarm.held", int'(alarm), 1);
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, "alarmrst");
      expectVal("alarmrst.alarm", int'(alarm), 0);
      expectVal("alarmrst.fail", int'(failCount), 0);
      expectVal("alarmrst.code", int'(busIf.key_code_o), 0);

      // Result timeout, then check_done winning against the timeout.
      applyStimulus(1'b1, 1'b1, 4'hE, 1'b0, 1'b0, "toEnter");
      idle(14, "toWait");
      expectVal("timeout.before", int'(failCount), 0);
      idle(1, "toHit");
      expectVal("timeout.fail", int'(failCount), 1);
      applyStimulus(1'b1, 1'b1, 4'hE, 1'b0, 1'b0, "precEnter");
      idle(14, "precWait");
      applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, "precDone");
      expectVal("prec.fail", int'(failCount), 0);
      applyStimulus(1'b1, 1'b1, 4'h9, 1'b0, 1'b0, "precKey");
      expectVal("prec.accept", int'(busIf.key_pulse_o), 1);

      // Reset in the last second of a lockout.
      for (int i = 0; i < 3; i++) failOnce("fail4");
      idle(10, "lock3wait");
      expectVal("lock3.secs", int'(lockSecs), 1);
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, "lock3rst");
      expectVal("lock3rst.secs", int'(lockSecs), 0);
      expectVal("lock3rst.fail", int'(failCount), 0);
      expectVal("lock3rst.lockout", int'(lockout), 0);
      applyStimulus(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, "lock3after");
      expectVal("lock3rst.accept", int'(busIf.key_pulse_o), 1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic       r;
         logic       kp;
         logic [3:0] kc;
         logic       cd;
         logic       mt;
         r  = ($urandom_range(0, 199) != 0);
         kp = ($urandom_range(0, 2) == 0);
         kc = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
         cd = ($urandom_range(0, 5) == 0);
         mt = ($urandom_range(0, 2) == 0);
         alarmClear = ($urandom_range(0, 49) == 0);
         applyStimulus(r, kp, kc, cd, mt, "rand");
         alarmClear = 1'b0;
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
